window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen_pkg.sv | 24 ++
 rtl/window_3x3_gen_line_buf.sv | 26 ++
 rtl/window_3x3_gen.sv | 113 +++++++++++
 tb/tb_window_3x3_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared types and constants for the 3x3 sliding-window generator.
// Tap indices address DATA_W-wide slots of win_out; 8 is the oldest (top-left).
package window_3x3_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;

  localparam int TAP_TL = 8;
  localparam int TAP_TC = 7;
  localparam int TAP_TR = 6;
  localparam int TAP_ML = 5;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 3;
  localparam int TAP_BL = 2;
  localparam int TAP_BC = 1;
  localparam int TAP_BR = 0;

endpackage

// File: rtl/window_3x3_gen_line_buf.sv
// Enable-gated delay line: dout is the sample written DEPTH enables ago.
// Contents are not reset; the window logic never exposes them before refill.
module window_3x3_gen_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 window generator built from two line buffers and a 3x3 shift window.
//   state  | meaning
//   IDLE   | waiting for sof&pix_valid; stray pixels are dropped
//   ACTIVE | accepting pixels of the current frame until (IMG_H-1, IMG_W-1)
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [9*DATA_W-1:0] win_out,
  output logic              win_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t state, state_nxt;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic accept, restart, last_pix, interior;
  logic [DATA_W-1:0] buf0_out, buf1_out;
  logic [DATA_W-1:0] win [9];

  // A sof-qualified pixel is always (0,0), even mid-frame, which abandons the old frame.
  assign restart  = pix_valid & sof;
  assign accept   = pix_valid & (sof | (state == ACTIVE));
  assign cur_col  = restart ? '0 : col;
  assign cur_row  = restart ? '0 : row;
  assign last_pix = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign interior = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = last_pix ? IDLE : ACTIVE;
  end

  always_comb begin
    busy = 1'b0;
    if (state == ACTIVE) busy = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= last_pix ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  window_3x3_gen_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_line_buf0 (
    .clk  (clk),
    .en   (accept),
    .din  (pix_in),
    .dout (buf0_out)
  );

  window_3x3_gen_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_line_buf1 (
    .clk  (clk),
    .en   (accept),
    .din  (buf0_out),
    .dout (buf1_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= interior;
      frame_done <= last_pix;
      if (accept) begin
        win[TAP_TL] <= win[TAP_TC];
        win[TAP_TC] <= win[TAP_TR];
        win[TAP_TR] <= buf1_out;
        win[TAP_ML] <= win[TAP_MC];
        win[TAP_MC] <= win[TAP_MR];
        win[TAP_MR] <= buf0_out;
        win[TAP_BL] <= win[TAP_BC];
        win[TAP_BC] <= win[TAP_BR];
        win[TAP_BR] <= pix_in;
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_win_out
    assign win_out[k*DATA_W +: DATA_W] = win[k];
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x4 frame with pixel value row*16+col.
module tb_window_3x3_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sof;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic [9*DW-1:0] win_out;
  logic          win_valid;
  logic          frame_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  window_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // Window whose newest pixel is (r,c): rows r-2..r, cols c-2..c, row-major, oldest in the MSBs.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[71 - 8*(dr*3 + dc) -: 8] = pv(r - 2 + dr, c - 2 + dc);
    return w;
  endfunction

  task automatic push(input logic s, input logic [7:0] p, input logic v);
    sof = s; pix_in = p; pix_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sof = 1'b0; pix_in = '0; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (win_out !== 72'h0) begin failures++; $display("FAIL reset_win_out got=%h exp=0", win_out); end
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    push(1'b1, 8'h77, 1'b1);
    checks++; if (busy !== 1'b0 || win_out !== 72'h0) begin
      failures++; $display("FAIL reset_hold busy=%b win_out=%h exp busy=0 win_out=0", busy, win_out);
    end
    rst = 1'b0;
    push(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_full_frame(input string tag);
    int nwin, ndone;
    logic ev, el;
    nwin = 0; ndone = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push(r == 0 && c == 0, pv(r, c), 1'b1);
        ev = (r >= 2 && c >= 2);
        el = (r == H-1 && c == W-1);
        checks++; if (win_valid !== ev) begin failures++; $display("FAIL %s win_valid r=%0d c=%0d got=%b exp=%b", tag, r, c, win_valid, ev); end
        if (ev) begin
          checks++; if (win_out !== exp_win(r, c)) begin failures++; $display("FAIL %s win_out r=%0d c=%0d got=%h exp=%h", tag, r, c, win_out, exp_win(r, c)); end
        end
        checks++; if (frame_done !== el) begin failures++; $display("FAIL %s frame_done r=%0d c=%0d got=%b exp=%b", tag, r, c, frame_done, el); end
        checks++; if (busy !== !el) begin failures++; $display("FAIL %s busy r=%0d c=%0d got=%b exp=%b", tag, r, c, busy, !el); end
        if (r == 2 && c == 2) begin
          checks++; if (win_out !== 72'h00_01_02_10_11_12_20_21_22) begin
            failures++; $display("FAIL %s first_window got=%h exp=000102101112202122", tag, win_out);
          end
        end
        if (win_valid === 1'b1) nwin++;
        if (frame_done === 1'b1) ndone++;
      end
    end
    checks++; if (nwin !== 6) begin failures++; $display("FAIL %s window_count got=%0d exp=6", tag, nwin); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL %s frame_done_count got=%0d exp=1", tag, ndone); end
    push(1'b0, 8'h5A, 1'b0);
    checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s post_frame valid=%b done=%b busy=%b exp 0/0/0", tag, win_valid, frame_done, busy);
    end
    checks++; if (win_out !== exp_win(H-1, W-1)) begin failures++; $display("FAIL %s post_frame_hold got=%h exp=%h", tag, win_out, exp_win(H-1, W-1)); end
  endtask

  task automatic test_stall();
    logic ev, el;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push(r == 0 && c == 0, pv(r, c), 1'b1);
        ev = (r >= 2 && c >= 2);
        el = (r == H-1 && c == W-1);
        checks++; if (win_valid !== ev) begin failures++; $display("FAIL v2 win_valid r=%0d c=%0d got=%b exp=%b", r, c, win_valid, ev); end
        if (ev) begin
          checks++; if (win_out !== exp_win(r, c)) begin failures++; $display("FAIL v2 win_out r=%0d c=%0d got=%h exp=%h", r, c, win_out, exp_win(r, c)); end
        end
        checks++; if (frame_done !== el) begin failures++; $display("FAIL v2 frame_done r=%0d c=%0d got=%b exp=%b", r, c, frame_done, el); end
        push(1'b0, 8'hEE, 1'b0);
        checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
          failures++; $display("FAIL v2 stall_strobes r=%0d c=%0d valid=%b done=%b exp 0/0", r, c, win_valid, frame_done);
        end
        checks++; if (busy !== !el) begin failures++; $display("FAIL v2 stall_busy r=%0d c=%0d got=%b exp=%b", r, c, busy, !el); end
        if (ev) begin
          checks++; if (win_out !== exp_win(r, c)) begin failures++; $display("FAIL v2 stall_hold r=%0d c=%0d got=%h exp=%h", r, c, win_out, exp_win(r, c)); end
        end
      end
    end
  endtask

  task automatic test_idle_drop();
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 8'hA0 + 8'(i), 1'b1);
      checks++; if (win_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        failures++; $display("FAIL v3 idle_drop i=%0d valid=%b busy=%b done=%b exp 0/0/0", i, win_valid, busy, frame_done);
      end
      checks++; if (win_out !== exp_win(H-1, W-1)) begin failures++; $display("FAIL v3 idle_hold i=%0d got=%h exp=%h", i, win_out, exp_win(H-1, W-1)); end
    end
    test_full_frame("v3");
  endtask

  task automatic test_restart();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 2 && c >= 3)) begin
          push(r == 0 && c == 0, pv(r, c), 1'b1);
          checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL v4 partial r=%0d c=%0d done=%b busy=%b exp 0/1", r, c, frame_done, busy);
          end
        end
      end
    end
    test_full_frame("v4");
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 3 || c == 0) push(r == 0 && c == 0, pv(r, c), 1'b1);
      end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL v5 pre_reset_busy got=%b exp=1", busy); end
    sof = 1'b0; pix_in = pv(3, 1); pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (win_out !== 72'h0) begin failures++; $display("FAIL v5 async_win_out got=%h exp=0", win_out); end
    checks++; if (busy !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL v5 async_flags busy=%b valid=%b done=%b exp 0/0/0", busy, win_valid, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push(1'b0, pv(3, 2), 1'b1);
    checks++; if (busy !== 1'b0 || win_valid !== 1'b0 || win_out !== 72'h0) begin
      failures++; $display("FAIL v5 needs_sof busy=%b valid=%b win_out=%h exp 0/0/0", busy, win_valid, win_out);
    end
    test_full_frame("v5");
  endtask

  initial begin
    test_reset();
    test_full_frame("v1");
    test_stall();
    test_idle_drop();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
